// File: rtl/keypad_emulator.sv
// Device-side emulator of a 4x4 active-low row/column matrix keypad driven by a row scanner.
// Optional contact bounce before the hold phase is enabled by defining KEYPAD_EMU_BOUNCE_EN.
module keypad_emulator #(
    parameter int unsigned HOLD_CYCLES   = 1000,
    parameter int unsigned GAP_CYCLES    = 1000,
    parameter int unsigned BOUNCE_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_code,
    input  logic       press_req,
    output logic       press_ready,
    output logic       press_done,
    output logic       pressed,
    input  logic [3:0] filas,
    output logic [3:0] columnas
);

    localparam int unsigned MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned MAX_N  = (MAX_HG > BOUNCE_CYCLES) ? MAX_HG : BOUNCE_CYCLES;
    localparam int unsigned CNT_W  = $clog2(MAX_N + 1);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam logic [CNT_W-1:0] BOUNCE_LOAD = CNT_W'(BOUNCE_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
`ifdef KEYPAD_EMU_BOUNCE_EN
        BOUNCE,
`endif
        GAP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;
    logic             accept;
    logic [1:0]       row_q;
    logic [1:0]       col_q;

    // Returns {row, col} for a key code.
    function automatic logic [3:0] key_pos(input logic [3:0] code);
        logic [3:0] pos;
        case (code)
            4'h1: pos = {2'd0, 2'd0};
            4'h2: pos = {2'd0, 2'd1};
            4'h3: pos = {2'd0, 2'd2};
            4'hA: pos = {2'd0, 2'd3};
            4'h4: pos = {2'd1, 2'd0};
            4'h5: pos = {2'd1, 2'd1};
            4'h6: pos = {2'd1, 2'd2};
            4'hB: pos = {2'd1, 2'd3};
            4'h7: pos = {2'd2, 2'd0};
            4'h8: pos = {2'd2, 2'd1};
            4'h9: pos = {2'd2, 2'd2};
            4'hC: pos = {2'd2, 2'd3};
            4'hE: pos = {2'd3, 2'd0};
            4'h0: pos = {2'd3, 2'd1};
            4'hF: pos = {2'd3, 2'd2};
            default: pos = {2'd3, 2'd3};
        endcase
        return pos;
    endfunction

    assign accept   = press_req & press_ready;
    assign cnt_zero = (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef KEYPAD_EMU_BOUNCE_EN
                    state_next = BOUNCE;
`else
                    state_next = HOLD;
`endif
                end
            end
`ifdef KEYPAD_EMU_BOUNCE_EN
            BOUNCE: if (cnt_zero) state_next = HOLD;
`endif
            HOLD:   if (cnt_zero) state_next = GAP;
            GAP:    if (cnt_zero) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One down-counter serves every phase: load N-1 on entry, leave on zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
`ifdef KEYPAD_EMU_BOUNCE_EN
                        cnt <= BOUNCE_LOAD;
`else
                        cnt <= HOLD_LOAD;
`endif
                    end
                end
`ifdef KEYPAD_EMU_BOUNCE_EN
                BOUNCE: cnt <= cnt_zero ? HOLD_LOAD : cnt - 1'b1;
`endif
                HOLD:   cnt <= cnt_zero ? GAP_LOAD : cnt - 1'b1;
                GAP:    cnt <= cnt_zero ? '0 : cnt - 1'b1;
                default: cnt <= '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else if (accept) begin
            {row_q, col_q} <= key_pos(key_code);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_done <= 1'b0;
        end else begin
            press_done <= (state == GAP) && cnt_zero;
        end
    end

`ifdef KEYPAD_EMU_BOUNCE_EN
    logic [1:0] bounce_tick;
    logic       bounce_lvl;

    // Contact level starts closed and flips after every fourth bounce cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bounce_tick <= '0;
            bounce_lvl  <= 1'b0;
        end else if (accept) begin
            bounce_tick <= '0;
            bounce_lvl  <= 1'b1;
        end else if (state == BOUNCE) begin
            bounce_tick <= bounce_tick + 1'b1;
            if (bounce_tick == 2'd3) begin
                bounce_lvl <= ~bounce_lvl;
            end
        end
    end
`endif

    always_comb begin
        press_ready = (state == IDLE);
        pressed     = 1'b0;
        case (state)
            HOLD:   pressed = 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
            BOUNCE: pressed = bounce_lvl;
`endif
            default: pressed = 1'b0;
        endcase
    end

    // Purely combinational, like a physical switch between row and column.
    always_comb begin
        columnas = '1;
        if (pressed && !filas[row_q]) begin
            columnas[col_q] = 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_emulator.sv
// Self-checking bench for keypad_emulator: randomized presses checked against a keymap-based model.
module tb_keypad_emulator;

    localparam int H = 4;
    localparam int G = 3;
`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam int B = 16;
`else
    localparam int B = 0;
`endif
    localparam int LAST = B + H + G;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key_code;
    logic       press_req;
    logic       press_ready;
    logic       press_done;
    logic       pressed;
    logic [3:0] filas;
    logic [3:0] columnas;

    int vectors = 0;
    int miscompares = 0;

    logic [3:0] keymap [4][4];

    keypad_emulator #(
        .HOLD_CYCLES  (H),
        .GAP_CYCLES   (G),
        .BOUNCE_CYCLES(16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_code   (key_code),
        .press_req  (press_req),
        .press_ready(press_ready),
        .press_done (press_done),
        .pressed    (pressed),
        .filas      (filas),
        .columnas   (columnas)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic void locate(input logic [3:0] code, output int r, output int c);
        r = 0;
        c = 0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (keymap[i][j] == code) begin
                    r = i;
                    c = j;
                end
    endfunction

    // Contact level k cycles after the accept edge.
    function automatic logic exp_pressed(input int k);
        if (k < B) return ((k / 4) % 2) == 0;
        if (k < B + H) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] exp_cols(input logic p, input logic [3:0] f, input int r, input int c);
        logic [3:0] v;
        v = 4'hF;
        if (p && f[r] == 1'b0) v[c] = 1'b0;
        return v;
    endfunction

    // Drives one full press and checks every cycle up to and including the done cycle.
    task automatic run_press(input logic [3:0] code, input bit do_accept, input bit scan,
                             input bit spurious, input bit chain, input logic [3:0] next_code,
                             output int n_pairs, output logic [3:0] pf, output logic [3:0] pc);
        int r, c;
        logic ep;
        logic [3:0] ec;
        logic [3:0] one;
        bit seen [256];
        one = 4'b0001;
        n_pairs = 0;
        pf = 4'hF;
        pc = 4'hF;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        locate(code, r, c);
        if (do_accept) begin
            key_code  = code;
            press_req = 1'b1;
            tick;
            press_req = 1'b0;
        end
        for (int k = 0; k <= LAST; k++) begin
            filas = scan ? ~(one << (k % 4)) : 4'($urandom);
            if (spurious && k < LAST) begin
                press_req = 1'($urandom_range(0, 1));
                key_code  = 4'($urandom);
            end else begin
                press_req = chain && (k == LAST);
                if (chain && k == LAST) key_code = next_code;
            end
            #1;
            ep = exp_pressed(k);
            ec = exp_cols(ep, filas, r, c);
            vectors++;
            if (pressed !== ep) begin
                miscompares++;
                $display("FAIL pressed key=%h k=%0d got=%b exp=%b", code, k, pressed, ep);
            end
            vectors++;
            if (columnas !== ec) begin
                miscompares++;
                $display("FAIL columnas key=%h k=%0d filas=%b got=%b exp=%b", code, k, filas, columnas, ec);
            end
            vectors++;
            if (press_ready !== (k == LAST)) begin
                miscompares++;
                $display("FAIL press_ready key=%h k=%0d got=%b exp=%b", code, k, press_ready, k == LAST);
            end
            vectors++;
            if (press_done !== (k == LAST)) begin
                miscompares++;
                $display("FAIL press_done key=%h k=%0d got=%b exp=%b", code, k, press_done, k == LAST);
            end
            if (scan && columnas !== 4'hF && !seen[{filas, columnas}]) begin
                seen[{filas, columnas}] = 1'b1;
                n_pairs++;
                pf = filas;
                pc = columnas;
            end
            if (k < LAST) tick;
        end
        if (chain) begin
            tick;
            press_req = 1'b0;
        end else begin
            press_req = 1'b0;
            tick;
            vectors++;
            if (press_done !== 1'b0 || press_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL after_done key=%h got done=%b ready=%b exp done=0 ready=1", code, press_done, press_ready);
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            filas = 4'($urandom);
            #1;
            vectors++;
            if ({press_ready, press_done, pressed, columnas} !== {3'b100, 4'hF}) begin
                miscompares++;
                $display("FAIL reset ready/done/pressed/cols got=%b%b%b %b exp=100 1111",
                         press_ready, press_done, pressed, columnas);
            end
            tick;
        end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_key5_directed;
        int k;
        key_code  = 4'h5;
        press_req = 1'b1;
        filas     = 4'hF;
        tick;
        press_req = 1'b0;
        k = 0;
        repeat (B + 1) begin
            tick;
            k++;
        end
        filas = 4'b1101;
        #1;
        vectors++;
        if (columnas !== 4'b1101) begin
            miscompares++;
            $display("FAIL key5_row1 got=%b exp=1101", columnas);
        end
        filas = 4'b1110;
        #1;
        vectors++;
        if (columnas !== 4'b1111) begin
            miscompares++;
            $display("FAIL key5_row0 got=%b exp=1111", columnas);
        end
        while (press_done !== 1'b1 && k < 100) begin
            tick;
            k++;
        end
        vectors++;
        if (k !== LAST) begin
            miscompares++;
            $display("FAIL key5_done_latency got=%0d exp=%0d", k, LAST);
        end
        tick;
    endtask

    task automatic test_random_press;
        int n;
        logic [3:0] pf, pc;
        for (int i = 0; i < 6; i++)
            run_press(4'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, n, pf, pc);
    endtask

    task automatic test_sweep;
        int n, r, c;
        logic [3:0] pf, pc, one;
        one = 4'b0001;
        for (int code = 0; code < 16; code++) begin
            run_press(4'(code), 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, n, pf, pc);
            locate(4'(code), r, c);
            vectors++;
            if (n !== 1 || pf !== ~(one << r) || pc !== ~(one << c)) begin
                miscompares++;
                $display("FAIL sweep key=%h got pairs=%0d filas=%b cols=%b exp pairs=1 filas=%b cols=%b",
                         code, n, pf, pc, ~(one << r), ~(one << c));
            end
        end
    endtask

    task automatic test_ignore;
        int n;
        logic [3:0] pf, pc;
        for (int i = 0; i < 4; i++)
            run_press(4'($urandom), 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, n, pf, pc);
    endtask

    task automatic test_back_to_back;
        int n;
        logic [3:0] pf, pc;
        run_press(4'h3, 1'b1, 1'b0, 1'b0, 1'b1, 4'hC, n, pf, pc);
        run_press(4'hC, 1'b0, 1'b0, 1'b0, 1'b1, 4'hE, n, pf, pc);
        run_press(4'hE, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, n, pf, pc);
    endtask

    task automatic test_reset_mid;
        bit saw_done;
        key_code  = 4'hD;
        press_req = 1'b1;
        filas     = 4'hF;
        tick;
        press_req = 1'b0;
        repeat (B + 2) tick;
        filas = 4'b0111;
        #1;
        vectors++;
        if (columnas !== 4'b0111) begin
            miscompares++;
            $display("FAIL midrst_before got=%b exp=0111", columnas);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({columnas, pressed, press_ready, press_done} !== 7'b1111_0_1_0) begin
            miscompares++;
            $display("FAIL midrst_async got cols=%b pressed=%b ready=%b done=%b exp 1111 0 1 0",
                     columnas, pressed, press_ready, press_done);
        end
        #2;
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < LAST + 4; i++) begin
            tick;
            if (press_done === 1'b1) saw_done = 1'b1;
        end
        vectors++;
        if (saw_done !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_no_done got=%b exp=0", saw_done);
        end
    endtask

    initial begin
        keymap = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                   '{4'h4, 4'h5, 4'h6, 4'hB},
                   '{4'h7, 4'h8, 4'h9, 4'hC},
                   '{4'hE, 4'h0, 4'hF, 4'hD}};
        rst_n     = 1'b0;
        press_req = 1'b0;
        key_code  = 4'h0;
        filas     = 4'hF;
        #2;
        test_reset;
        test_key5_directed;
        test_random_press;
        test_sweep;
        test_ignore;
        test_back_to_back;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
